// File: rtl/rom_port_arbiter.sv
// Two-port arbiter (data load over instruction fetch, with fetch starvation guard)
// in front of a shared program ROM with one-cycle registered read data.
// Optional build macro ROM_ARB_ALIGN_CHK_EN flags misaligned word addresses.
module rom_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              ld_err,

    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              busy
);

    localparam int CNT_RAW = $clog2(STARVE_MAX + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt;
    logic              force_if;
    logic              if_win;
    logic              ld_win;
    logic [ADDR_W-1:0] gnt_addr;
    logic              misalign;

    logic              pend;
    logic              sel_ld;
    logic              err_q;

    // NOTE: grants are gated with rst_n so nothing is granted, and no ROM
    // address leaves the block, while reset is held.
    always_comb begin
        force_if = if_req && (starve_cnt == STARVE_LIM);
        if_win   = rst_n && if_req && (force_if || !ld_req);
        ld_win   = rst_n && ld_req && !force_if;
        gnt_addr = '0;
        if (ld_win)
            gnt_addr = ld_addr;
        else if (if_win)
            gnt_addr = if_addr;
    end

`ifdef ROM_ARB_ALIGN_CHK_EN
    assign misalign = (if_win || ld_win) && (gnt_addr[1:0] != 2'b00);
    assign rom_addr = misalign ? '0 : gnt_addr;
`else
    assign misalign = 1'b0;
    assign rom_addr = gnt_addr;
`endif

    assign if_gnt = if_win;
    assign ld_gnt = ld_win;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_req && !if_win) begin
            if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Response tracking: one grant per cycle, answered exactly one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            sel_ld <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend   <= if_win || ld_win;
            sel_ld <= ld_win;
            err_q  <= misalign;
        end
    end

    always_comb begin
        if_rvalid = pend && !sel_ld;
        ld_rvalid = pend && sel_ld;
        if_rdata  = (if_rvalid && !err_q) ? rom_data : 32'h0;
        ld_rdata  = (ld_rvalid && !err_q) ? rom_data : 32'h0;
        busy      = pend;
    end

`ifdef ROM_ARB_ALIGN_CHK_EN
    assign if_err = if_rvalid && err_q;
    assign ld_err = ld_rvalid && err_q;
`else
    assign if_err = 1'b0;
    assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: stimulus pushes expected responses,
// a monitor pops and compares them against the response ports each cycle.
module tb_rom_port_arbiter;

    localparam int ADDR_W     = 12;
    localparam int STARVE_MAX = 3;

    logic              clk;
    logic              rst_n;
    logic              if_req, ld_req;
    logic [ADDR_W-1:0] if_addr, ld_addr;
    logic              if_gnt, if_rvalid, if_err;
    logic              ld_gnt, ld_rvalid, ld_err;
    logic [31:0]       if_rdata, ld_rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              busy;

    rom_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: byte array, little-endian word read, one-cycle registered.
    logic [7:0] rom_mem [0:4095];

    function automatic logic [31:0] rom_word(input int a);
        return {rom_mem[(a + 3) & 4095], rom_mem[(a + 2) & 4095],
                rom_mem[(a + 1) & 4095], rom_mem[a & 4095]};
    endfunction

    always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_ld;
        logic [31:0] data;
        bit          err;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    streak   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares response ports against the scoreboard every cycle.
    initial begin
        resp_t it;
        bit    due;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      {if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err, busy,
                       rom_addr, if_rdata, ld_rdata}, '0);
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc - 1) begin
                    void'(exp_q.pop_front());
                    check("resp_missed", 1, 0);
                end
                due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc - 1);
                if (due) it = exp_q.pop_front();
                else     it = '{cyc: 0, is_ld: 1'b0, data: 32'h0, err: 1'b0};
                check("resp_flags",
                      {if_rvalid, ld_rvalid, if_err, ld_err, busy},
                      {due && !it.is_ld, due && it.is_ld,
                       due && !it.is_ld && it.err, due && it.is_ld && it.err, due});
                check("if_rdata", if_rdata, (due && !it.is_ld) ? it.data : 32'h0);
                check("ld_rdata", ld_rdata, (due && it.is_ld) ? it.data : 32'h0);
            end
        end
    end

    // One request cycle: drive, predict from the arbitration rules, compare grants.
    task automatic cycle(input logic ir, input logic [ADDR_W-1:0] ia,
                         input logic lr, input logic [ADDR_W-1:0] la,
                         output logic [1:0] got);
        bit                exp_if, exp_ld, bad;
        logic [ADDR_W-1:0] ga, ea;
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
        exp_if = ir && (streak >= STARVE_MAX || !lr);
        exp_ld = lr && !exp_if;
        ga     = exp_ld ? la : (exp_if ? ia : '0);
`ifdef ROM_ARB_ALIGN_CHK_EN
        bad = (exp_if || exp_ld) && (ga % 4 != 0);
`else
        bad = 1'b0;
`endif
        ea = bad ? '0 : ga;
        @(negedge clk);
        got = {if_gnt, ld_gnt};
        check("grant", got, {exp_if, exp_ld});
        check("rom_addr", rom_addr, ea);
        if (exp_if || exp_ld)
            exp_q.push_back('{cyc: cyc, is_ld: exp_ld, data: bad ? 32'h0 : rom_word(int'(ga)), err: bad});
        if (ir && !exp_if) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
        else               streak = 0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(0, 4095));
        if ($urandom_range(0, 9) < 8) a[1:0] = 2'b00;
        return a;
    endfunction

    logic [1:0] g;
    logic [1:0] starve_pat [0:4];

    initial begin
        logic              ir, lr;
        logic [ADDR_W-1:0] ia, la;

        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        rom_mem[16] = 8'h93; rom_mem[17] = 8'h00; rom_mem[18] = 8'h50; rom_mem[19] = 8'h00;
        starve_pat[0] = 2'b01; starve_pat[1] = 2'b01; starve_pat[2] = 2'b01;
        starve_pat[3] = 2'b10; starve_pat[4] = 2'b01;

        rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single fetch, then idle so its response is seen alone.
        cycle(1'b1, 12'h010, 1'b0, 12'h000, g);
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);
        check("idle_no_grant", g, 2'b00);

        // Contention: load wins.
        cycle(1'b1, 12'h040, 1'b1, 12'h100, g);
        check("contention_ld_wins", g, 2'b01);
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);

        // Starvation: ld, ld, ld, if, ld.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 12'h080, 1'b1, 12'h200 + 12'(4 * i), g);
            check("starve_pattern", g, starve_pat[i]);
        end
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);

        // Streaming: alternating single requests for 8 cycles.
        for (int i = 0; i < 8; i++)
            cycle(i % 2 == 0, 12'(4 * i), i % 2 == 1, 12'h300 + 12'(4 * i), g);
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);

        // Alignment case (expected behaviour depends on the build macro).
        cycle(1'b0, 12'h000, 1'b1, 12'h102, g);
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);

        // Reset mid-transaction after building up starvation count.
        cycle(1'b1, 12'h020, 1'b1, 12'h400, g);
        cycle(1'b1, 12'h020, 1'b1, 12'h404, g);
        #1;
        rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0;
        exp_q.delete();
        streak = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 12'h020, 1'b1, 12'h500, g);
            check("post_reset_starve", g, starve_pat[i]);
        end

        // Randomized traffic honouring hold-until-grant.
        ir = 1'b0; lr = 1'b0; ia = '0; la = '0; g = 2'b00;
        for (int i = 0; i < 400; i++) begin
            if (!(ir && !g[1])) begin
                ir = ($urandom_range(0, 9) < 6); ia = rand_addr();
            end else if ($urandom_range(0, 9) == 0) begin
                ir = 1'b0;
            end
            if (!(lr && !g[0])) begin
                lr = ($urandom_range(0, 9) < 6); la = rand_addr();
            end else if ($urandom_range(0, 9) == 0) begin
                lr = 1'b0;
            end
            cycle(ir, ia, lr, la, g);
        end
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);
        cycle(1'b0, 12'h000, 1'b0, 12'h000, g);
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the byte-address width of the shared program ROM (4096 bytes).
REQ-002 The block SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive denied fetch cycles before the fetch port is forced to win.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have ports if_req (input, 1), if_addr (input, ADDR_W), if_gnt (output, 1), if_rvalid (output, 1), if_rdata (output, 32) and if_err (output, 1), forming the instruction-fetch requester port.
REQ-006 The block SHALL have ports ld_req (input, 1), ld_addr (input, ADDR_W), ld_gnt (output, 1), ld_rvalid (output, 1), ld_rdata (output, 32) and ld_err (output, 1), forming the data-load requester port.
REQ-007 The block SHALL have port rom_addr, output, ADDR_W, the byte address driven to the ROM.
REQ-008 The block SHALL have port rom_data, input, 32, the little-endian ROM word, registered inside the ROM one clock after its address.
REQ-009 The block SHALL have port busy, output, 1, high while a response is pending.

Function
REQ-010 At most one request SHALL be granted per cycle; a grant is combinational in the request cycle N, with rom_addr equal to the granted port's address in cycle N.
REQ-011 Default priority SHALL be ld over if: ld_req granted whenever high, unless the starvation rule applies.
REQ-012 A saturating starvation counter (width clog2(STARVE_MAX+1)) SHALL increment each cycle if_req=1 and if_gnt=0, clear when if_gnt=1 or if_req=0, and saturate at STARVE_MAX.
REQ-013 When the counter equals STARVE_MAX and if_req=1, the fetch port SHALL be granted that cycle regardless of ld_req; the load port is denied that cycle.
REQ-014 With no request, both grants SHALL be 0 and rom_addr SHALL be 0.
REQ-015 Requesters SHALL hold req and addr stable until gnt; a requester dropping req before gnt causes no ROM access and no response.
REQ-016 A registered response-select flag and pending bit SHALL record the granted port; in cycle N+1 exactly that port's rvalid SHALL be 1 for one cycle, with rdata = rom_data.
REQ-017 Latency SHALL be exactly one cycle from gnt to rvalid; back-to-back grants every cycle SHALL be sustained with no bubble.
REQ-018 The non-selected port's rdata SHALL read 0; busy SHALL equal the pending bit.
REQ-019 Grants in cycle N+1 SHALL be independent of the response delivered in N+1 (full pipelining, no stall input).

Reset
REQ-020 While rst_n=0: if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err and busy SHALL be 0; if_rdata, ld_rdata and rom_addr SHALL be 0; the starvation counter and response-select flag SHALL be 0.
REQ-021 A reset asserted between grant and response SHALL drop that response; no rvalid follows reset release.
REQ-022 The first grant SHALL occur no earlier than the first rising edge-free cycle after rst_n deasserts, following the normal priority rules.

Configuration
REQ-023 With macro ROM_ARB_ALIGN_CHK_EN defined, a granted request with addr[1:0] != 0 SHALL still be granted and answered in N+1, but with that port's err=1 and rdata=0; rom_addr SHALL be driven 0 for it.
REQ-024 Without ROM_ARB_ALIGN_CHK_EN, if_err and ld_err SHALL be constant 0 and addresses SHALL pass unmodified, whatever their alignment.

Verification
REQ-025 The bench SHALL check single fetch: if_req=1, if_addr=0x010 for one cycle, rom_data=0x00500093 -> if_gnt=1 and rom_addr=0x010 that cycle; if_rvalid=1, if_rdata=0x00500093 next cycle; ld_rvalid=0.
REQ-026 The bench SHALL check contention: if_req=ld_req=1 in the same cycle, ld_addr=0x100 -> ld_gnt=1, if_gnt=0, rom_addr=0x100.
REQ-027 The bench SHALL check starvation with STARVE_MAX=3: ld_req and if_req held high -> ld wins cycles 1-3, if_gnt=1 in cycle 4, ld wins cycle 5.
REQ-028 The bench SHALL check streaming: alternating if and ld grants every cycle for 8 cycles -> 8 rvalid pulses each one cycle after its grant, routed to the correct port, busy continuously 1.
REQ-029 The bench SHALL check reset mid-transaction: grant at cycle N, rst_n=0 before edge N+1 -> no rvalid, all outputs 0, counter 0.
REQ-030 The bench SHALL check alignment with ROM_ARB_ALIGN_CHK_EN defined: ld_addr=0x102 -> ld_gnt=1, rom_addr=0, next cycle ld_rvalid=1, ld_err=1, ld_rdata=0; without the macro, ld_err stays 0 and rom_addr=0x102.
